ram16_arbiter: RTL and testbench
================================

Name: ram16_arbiter

Overview:
Shares one ram16-style 16-entry, 1-bit-per-lane, 1-cycle-latency RAM bank between NREQ requesters using round-robin arbitration. The RAM has no reset, so after every reset the block first sweeps all 16 addresses with zeros before it grants any access. It sits between processing blocks and a DW-wide bank of ram16 cells sharing one address and one write enable.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 1, data width = number of parallel ram16 cells in the bank

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req  in  NREQ  per-requester access request
we  in  NREQ  per-requester write (1) / read (0)
addr  in  NREQ*4  per-requester address; slice i = bits [4i+3:4i]
wdata  in  NREQ*DW  per-requester write data; slice i = bits [DW*i+DW-1:DW*i]
gnt  out  NREQ  one-hot acceptance, same cycle as req
rvalid  out  1  response valid
rid  out  log2(NREQ) (min 1)  index of the requester whose response is valid
rdata  out  DW  response data (read value, or written value on writes)
busy  out  1  init sweep in progress
ram_we  out  1  to ram16 write_enable
ram_set  out  DW  to ram16 set
ram_a0..ram_a3  out  1 each  to ram16 a0..a3; a0 = address MSB (addr[3]), a3 = LSB
ram_result  in  DW  from ram16 result

Behaviour:
- Two states: INIT and RUN. Reset enters INIT with sweep counter = 0.
- Reset values, held while rst=1: gnt=0, rvalid=0, rid=0, busy=1, ram_we=0, ram address=0, ram_set=0, round-robin pointer=0.
- INIT:
  - Sweep cycle k (k = 0..15) is the (k+1)th cycle after rst deasserts. It drives ram_we=1, ram_set=0, ram address=k.
  - busy=1 and gnt=0 throughout INIT; requests are ignored, not queued.
  - After sweep cycle 15 the block moves to RUN. busy=0 from the next cycle; the first grant is possible on cycle 16 after rst release.
  - The 4-bit counter does not wrap; the transition to RUN happens on count 15.
- RUN arbitration:
  - Exactly one grant per cycle when any req is high.
  - The winner is the first requester with req=1 searching from pointer p upward, modulo NREQ.
  - gnt is combinational from req and p, and is one-hot or zero.
  - Accepted means req[i] & gnt[i]; a requester that is not granted holds its request.
  - After accepting requester i, p <= (i+1) mod NREQ. With no accept, p is unchanged.
- RAM drive:
  - Accept cycle: ram_we=we[i], ram_set=wdata slice i, ram address=addr slice i.
  - Idle cycle: ram_we=0, address=0, set=0.
- Response:
  - rvalid=1 exactly one cycle after an accept. rid = accepted index. rdata = ram_result.
  - Because ram16 is write-through, a write returns the written value and a read returns stored data.
  - Back-to-back accepts give back-to-back rvalid pulses.
  - rvalid=0 in all other cycles, including every INIT cycle.
- Read-after-write to the same address on consecutive cycles returns the new value; no hazard logic is needed.
- Reset mid-operation: pending responses are discarded (rvalid=0 next cycle), p=0, and the full 16-cycle sweep reruns.
- rst asserted in the same cycle as a request: reset wins; no grant.

Decomposition:
- Shared package ram16_pkg:
  - RAM16_AW=4, RAM16_DEPTH=16.
  - State enum {ST_INIT, ST_RUN}.
  - Function splitting a 4-bit address into a0..a3.
- Sub-module rr_arbiter (NREQ parameter): inputs req, pointer; outputs one-hot gnt and winner index. Purely combinational.
- The pointer register stays in ram16_arbiter.

Test Plan:
- Reset release, all req=0: busy=1 for exactly 16 cycles; ram_we=1 with address 0..15 in order and set=0; busy=0 on cycle 16; a read of address 9 then returns rdata=0.
- Requests during INIT: req=2'b11 held from reset release -> gnt=0 until cycle 16; first grant goes to requester 0 (p=0), then requester 1 on cycle 17.
- Write/read latency: requester 1 writes DW=1 value 1 to address 0xA (a0..a3=1,0,1,0), then reads 0xA on the next cycle -> rvalid with rid=1, rdata=1 on both following cycles.
- Fairness: both req held high for 8 cycles -> gnt alternates 01,10,01,...; 4 responses each; rid sequence matches the grant sequence delayed by 1.
- Single requester: only req[1] held for 3 cycles -> granted every cycle; p stays at 0 after each accept (p <= (1+1) mod 2 = 0).
- Mid-operation reset: assert rst one cycle after an accept -> rvalid stays 0, busy=1, the sweep restarts at address 0, and a previously written 1 at 0xA reads back 0 after the sweep.

Source files
------------

// File: rtl/ram16_pkg.sv
// Shared types and helpers for the ram16 bank and its arbiter.
package ram16_pkg;

  localparam int RAM16_AW    = 4;
  localparam int RAM16_DEPTH = 16;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // Address pins of one ram16 cell; a0 carries the address MSB.
  typedef struct packed {
    logic a0;
    logic a1;
    logic a2;
    logic a3;
  } ram16_pins_t;

  function automatic ram16_pins_t split_addr(input logic [RAM16_AW-1:0] a);
    ram16_pins_t p;
    p.a0 = a[3];
    p.a1 = a[2];
    p.a2 = a[1];
    p.a3 = a[0];
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win
);

  logic        found;
  int unsigned idx;

  // Scan NREQ positions starting at ptr, wrapping modulo NREQ.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < unsigned'(NREQ); off++) begin
      idx = 32'(ptr) + off;
      if (idx >= unsigned'(NREQ)) idx = idx - unsigned'(NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram16_arbiter.sv
// Round-robin sharing of one ram16 bank, with a zero-fill sweep after reset.
module ram16_arbiter
  import ram16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 1,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*RAM16_AW-1:0] addr,
  input  logic [NREQ*DW-1:0]       wdata,
  output logic [NREQ-1:0]          gnt,
  output logic                     rvalid,
  output logic [IW-1:0]            rid,
  output logic [DW-1:0]            rdata,
  output logic                     busy,
  output logic                     ram_we,
  output logic [DW-1:0]            ram_set,
  output logic                     ram_a0,
  output logic                     ram_a1,
  output logic                     ram_a2,
  output logic                     ram_a3,
  input  logic [DW-1:0]            ram_result
);

  state_t              state;
  logic [RAM16_AW-1:0] cnt;
  logic [IW-1:0]       ptr;
  logic                rvalid_q;
  logic [IW-1:0]       rid_q;

  logic [NREQ-1:0]     arb_gnt;
  logic [IW-1:0]       win;
  logic                accept;
  logic [RAM16_AW-1:0] ram_addr;
  ram16_pins_t         pins;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .win  (win)
  );

  // Outputs are forced to reset values combinationally while rst is high,
  // since the synchronous reset only reaches the registers at the next edge.
  assign gnt    = (state == ST_RUN && !rst) ? arb_gnt : '0;
  assign accept = |gnt;
  assign busy   = rst || (state == ST_INIT);
  assign rvalid = rvalid_q && !rst;
  assign rid    = rst ? '0 : rid_q;
  assign rdata  = ram_result;

  // RAM port drive: sweep address during INIT, winner's request on accept.
  always_comb begin
    ram_we   = 1'b0;
    ram_set  = '0;
    ram_addr = '0;
    if (!rst && state == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = cnt;
    end else if (accept) begin
      ram_we   = we[win];
      ram_set  = wdata[int'(win)*DW +: DW];
      ram_addr = addr[int'(win)*RAM16_AW +: RAM16_AW];
    end
  end

  assign pins   = split_addr(ram_addr);
  assign ram_a0 = pins.a0;
  assign ram_a1 = pins.a1;
  assign ram_a2 = pins.a2;
  assign ram_a3 = pins.a3;

  // Sweep/run FSM, round-robin pointer and one-cycle response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      ptr      <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
    end else begin
      rvalid_q <= accept;
      if (accept) rid_q <= win;
      case (state)
        ST_INIT: begin
          if (cnt == RAM16_AW'(RAM16_DEPTH - 1)) state <= ST_RUN;
          else                                   cnt   <= cnt + 1'b1;
        end
        ST_RUN: begin
          if (accept) ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram16_arbiter.sv
// Directed bench for ram16_arbiter (NREQ=2, DW=1) with a ram16 bank model.
module tb_ram16_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [NREQ*4-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] gnt;
  logic            rvalid;
  logic            rid;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            ram_we;
  logic [DW-1:0]   ram_set;
  logic            ram_a0, ram_a1, ram_a2, ram_a3;
  logic [DW-1:0]   ram_result;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] mem [16];
  logic [3:0]    a_obs;

  ram16_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rid        (rid),
    .rdata      (rdata),
    .busy       (busy),
    .ram_we     (ram_we),
    .ram_set    (ram_set),
    .ram_a0     (ram_a0),
    .ram_a1     (ram_a1),
    .ram_a2     (ram_a2),
    .ram_a3     (ram_a3),
    .ram_result (ram_result)
  );

  always #5 clk = ~clk;

  assign a_obs = {ram_a0, ram_a1, ram_a2, ram_a3};

  // Write-through ram16 bank: result shows the written value on writes.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '1;
    ram_result = '0;
  end
  always @(posedge clk) begin
    if (ram_we) begin
      mem[a_obs] <= ram_set;
      ram_result <= ram_set;
    end else begin
      ram_result <= mem[a_obs];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset two cycles, release, and check all 16 sweep cycles.
  task automatic reset_and_sweep();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_gnt",    32'(gnt),     0);
    chk("rst_rvalid", 32'(rvalid),  0);
    chk("rst_rid",    32'(rid),     0);
    chk("rst_busy",   32'(busy),    1);
    chk("rst_we",     32'(ram_we),  0);
    chk("rst_addr",   32'(a_obs),   0);
    chk("rst_set",    32'(ram_set), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("sweep_busy",   32'(busy),    1);
      chk("sweep_we",     32'(ram_we),  1);
      chk("sweep_addr",   32'(a_obs),   k);
      chk("sweep_set",    32'(ram_set), 0);
      chk("sweep_gnt",    32'(gnt),     0);
      chk("sweep_rvalid", 32'(rvalid),  0);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);

    // Plain sweep, then read address 9 -> zero.
    reset_and_sweep();
    req = 2'b01; we = 2'b00; addr = 8'h09;
    #1;
    chk("run_busy",  32'(busy),   0);
    chk("rd9_gnt",   32'(gnt),    1);
    chk("rd9_we",    32'(ram_we), 0);
    chk("rd9_addr",  32'(a_obs),  9);
    @(negedge clk);
    req = '0;
    #1;
    chk("rd9_rvalid", 32'(rvalid), 1);
    chk("rd9_rid",    32'(rid),    0);
    chk("rd9_rdata",  32'(rdata),  0);
    @(negedge clk);
    #1;
    chk("idle_rvalid", 32'(rvalid), 0);

    // Requests held through reset and INIT, then 8 cycles of fairness.
    req = 2'b11; addr = 8'h00;
    reset_and_sweep();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("fair_busy", 32'(busy), 0);
      chk("fair_gnt",  32'(gnt), (c % 2 == 0) ? 1 : 2);
      if (c > 0) begin
        chk("fair_rvalid", 32'(rvalid), 1);
        chk("fair_rid",    32'(rid), (c - 1) % 2);
        if (rvalid) begin
          if (rid) n1++; else n0++;
        end
      end
      @(negedge clk);
    end
    req = '0;
    #1;
    chk("fair_last_rvalid", 32'(rvalid), 1);
    chk("fair_last_rid",    32'(rid),    1);
    if (rvalid) begin
      if (rid) n1++; else n0++;
    end
    chk("fair_n0", 32'(n0), 4);
    chk("fair_n1", 32'(n1), 4);
    @(negedge clk);
    #1;
    chk("fair_end_rvalid", 32'(rvalid), 0);

    // Requester 1 writes 1 to 0xA, then reads it back.
    req = 2'b10; we = 2'b10; addr = 8'hA0; wdata = 2'b10;
    #1;
    chk("wr_gnt",  32'(gnt),     2);
    chk("wr_we",   32'(ram_we),  1);
    chk("wr_pins", 32'(a_obs),   'hA);
    chk("wr_set",  32'(ram_set), 1);
    @(negedge clk);
    we = 2'b00;
    #1;
    chk("rd_gnt",      32'(gnt),    2);
    chk("rd_we",       32'(ram_we), 0);
    chk("wr_rsp_v",    32'(rvalid), 1);
    chk("wr_rsp_rid",  32'(rid),    1);
    chk("wr_rsp_data", 32'(rdata),  1);
    @(negedge clk);
    req = '0;
    #1;
    chk("rd_rsp_v",    32'(rvalid), 1);
    chk("rd_rsp_rid",  32'(rid),    1);
    chk("rd_rsp_data", 32'(rdata),  1);
    @(negedge clk);

    // Single requester 1 granted every cycle; pointer returns to 0.
    req = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("single_gnt", 32'(gnt), 2);
      @(negedge clk);
    end
    req = 2'b11;
    #1;
    chk("ptr0_gnt", 32'(gnt), 1);
    @(negedge clk);

    // Write 0xA again, then reset right after the accept.
    req = 2'b10; we = 2'b10; addr = 8'hA0; wdata = 2'b10;
    #1;
    chk("wr2_gnt", 32'(gnt), 2);
    @(negedge clk);
    req = '0; we = '0;
    reset_and_sweep();
    req = 2'b11; addr = 8'hA0;
    #1;
    chk("post_rst_gnt", 32'(gnt), 1);
    @(negedge clk);
    req = 2'b10;
    #1;
    chk("post_rst_rd_gnt", 32'(gnt), 2);
    @(negedge clk);
    req = '0;
    #1;
    chk("post_rst_v",    32'(rvalid), 1);
    chk("post_rst_rid",  32'(rid),    1);
    chk("post_rst_data", 32'(rdata),  0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
